// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction-memory and decoder handshake bundle for inst_fetch
//
// Signals:
//   imem_req / imem_addr       fetch unit -> instruction memory read request
//   imem_ack / imem_data       instruction memory -> fetch unit one-cycle response
//   inst_valid / inst / inst_pc fetch unit -> decoder instruction slot
//   inst_ready                 decoder -> fetch unit accept
//   redirect / redirect_pc     branch unit -> fetch unit flush and retarget
// Modports:
//   master  the fetch unit side
//   slave   the environment side (memory, decoder, branch unit)

interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_data, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_data, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with 2-entry buffer and redirect flush
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    inst_fetch_if.master: memory request/response, decoder slot, redirect
// Parameter:
//   RESET_PC  first fetch address after reset (word aligned)

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    inst_fetch_if.master  bus
);

    // IDLE: nothing outstanding. WAIT: outstanding, response is kept.
    // DROP: outstanding, response belongs to a squashed path and is discarded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [31:0] pc_q [2];
    logic [31:0] pc_d [2];

    logic        pop;
    logic        push;
    logic        flush;
    logic [1:0]  cnt_after_pop;
    logic [1:0]  cnt_after_push;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    assign redirect_target      = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = bus.redirect;

        // A redirect squashes the decoder handshake as well as any push.
        pop            = (count_q != 2'd0) && bus.inst_ready && !bus.redirect;
        cnt_after_pop  = count_q - {1'b0, pop};
        cnt_after_push = cnt_after_pop + 2'd1;

        case (state_q)
            IDLE: begin
                // Only start a request if there will be room for its response.
                if (!bus.redirect && (cnt_after_pop < 2'd2)) begin
                    state_d = WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    state_d = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = addr_q + 32'd4;
                    if (cnt_after_push < 2'd2) begin
                        state_d = WAIT;
                        addr_d  = addr_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.redirect) begin
            fetch_pc_d = redirect_target;
        end

        if (flush) begin
            count_d = 2'd0;
        end else if (push) begin
            count_d = cnt_after_push;
        end else begin
            count_d = cnt_after_pop;
        end

        data_d   = data_q;
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                data_d[wr_ptr_q] = bus.imem_data;
                pc_d[wr_ptr_q]   = addr_q;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= data_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

    assign bus.imem_req   = (state_q != IDLE);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = (count_q != 2'd0);
    // Zero the slot when empty so the decoder never sees a flushed word.
    assign bus.inst       = bus.inst_valid ? data_q[rd_ptr_q] : 32'd0;
    assign bus.inst_pc    = bus.inst_valid ? pc_q[rd_ptr_q] : 32'd0;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard testbench for inst_fetch

module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if bus();

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb [$];
    int          ack_lat  = 0;
    int          wait_cnt = 0;
    bit          stray    = 1'b0;
    int          cyc      = 0;
    bit          prev_req = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    bit          chk_gap  = 1'b0;
    bit          gap_armed = 1'b0;
    int          last_pop = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a falling edge: drives the memory response and scores the
    // decoder handshake that the next rising edge will perform.
    task automatic cycle();
        logic [31:0] e;
        if (rst_n && prev_req && !prev_ack && bus.imem_req)
            check("addr_stable", bus.imem_addr, prev_addr);
        if (stray) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = 32'hDEAD_BEEF;
        end else if (bus.imem_req) begin
            if (wait_cnt >= ack_lat) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = mem_word(bus.imem_addr);
                wait_cnt      = 0;
            end else begin
                bus.imem_ack  = 1'b0;
                wait_cnt      = wait_cnt + 1;
            end
        end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
        end
        prev_req  = bus.imem_req;
        prev_addr = bus.imem_addr;
        prev_ack  = bus.imem_ack;
        if (rst_n && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("inst_pc", bus.inst_pc, e);
                check("inst", bus.inst, mem_word(e));
            end
            if (chk_gap) begin
                if (gap_armed) check("stream_gap", 32'(cyc - last_pop), 32'd1);
                gap_armed = 1'b1;
                last_pop  = cyc;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && sb.size() != 0; i++) cycle();
        check(tag, 32'(sb.size()), 32'd0);
        sb.delete();
        bus.inst_ready = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        cycle();
        bus.redirect    = 1'b0;
    endtask

    initial begin
        bus.imem_ack    = 1'b0;
        bus.imem_data   = 32'd0;
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;

        // Reset state
        @(negedge clk);
        cycle();
        cycle();
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);

        // Streaming with zero-wait memory and an always-ready decoder,
        // crossing the 2^32 wrap.
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        ack_lat        = 0;
        sb.push_back(32'hFFFF_FFF8);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0000_0000);
        sb.push_back(32'h0000_0004);
        sb.push_back(32'h0000_0008);
        sb.push_back(32'h0000_000C);
        chk_gap = 1'b1;
        cycle();
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, RST_PC);
        check("first_valid", 32'(bus.inst_valid), 32'd0);
        cycle();
        check("latency_valid", 32'(bus.inst_valid), 32'd1);
        drain("stream_drained");
        chk_gap = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Stalled decoder: exactly two words buffered, then request stops.
        do_redirect(32'h0000_0000);
        check("flush_valid", 32'(bus.inst_valid), 32'd0);
        sb.push_back(32'h0000_0000);
        sb.push_back(32'h0000_0004);
        for (int i = 0; i < 8; i++) cycle();
        check("full_req", 32'(bus.imem_req), 32'd0);
        check("full_valid", 32'(bus.inst_valid), 32'd1);
        check("full_head_pc", bus.inst_pc, 32'h0000_0000);
        check("full_head", bus.inst, mem_word(32'h0000_0000));
        bus.inst_ready = 1'b1;
        drain("full_drained");
        for (int i = 0; i < 6; i++) cycle();

        // Redirect while waiting: late response dropped, refetch at aligned target.
        ack_lat = 2;
        do_redirect(32'h0000_0200);
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_addr == 32'h0000_0200); i++) cycle();
        check("wait_0200", bus.imem_addr, 32'h0000_0200);
        do_redirect(32'h0000_0103);
        check("drop_req", 32'(bus.imem_req), 32'd1);
        check("drop_addr", bus.imem_addr, 32'h0000_0200);
        check("drop_valid", 32'(bus.inst_valid), 32'd0);
        bus.inst_ready = 1'b1;
        sb.push_back(32'h0000_0100);
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_addr != 32'h0000_0200); i++) cycle();
        check("refetch_addr", bus.imem_addr, 32'h0000_0100);
        drain("refetch_drained");
        for (int i = 0; i < 6; i++) cycle();

        // Redirect coinciding with ack and pop at count=1.
        ack_lat = 0;
        do_redirect(32'h0000_0300);
        sb.push_back(32'h0000_0300);
        sb.push_back(32'h0000_0304);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 30 && sb.size() != 0; i++) cycle();
        check("pre_collide_req", 32'(bus.imem_req), 32'd1);
        check("pre_collide_valid", 32'(bus.inst_valid), 32'd1);
        do_redirect(32'h0000_0400);
        check("collide_valid", 32'(bus.inst_valid), 32'd0);
        check("collide_idle", 32'(bus.imem_req), 32'd0);
        sb.push_back(32'h0000_0400);
        cycle();
        check("collide_req", 32'(bus.imem_req), 32'd1);
        check("collide_addr", bus.imem_addr, 32'h0000_0400);
        drain("collide_drained");
        for (int i = 0; i < 6; i++) cycle();

        // Reset mid-request, then a stray ack right after release.
        ack_lat = 5;
        do_redirect(32'h0000_0500);
        for (int i = 0; i < 20 && !(bus.imem_req && bus.imem_addr == 32'h0000_0500); i++) cycle();
        check("pre_rst_req", 32'(bus.imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(bus.imem_req), 32'd0);
        check("async_rst_valid", 32'(bus.inst_valid), 32'd0);
        cycle();
        rst_n = 1'b1;
        stray = 1'b1;
        cycle();
        stray = 1'b0;
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, RST_PC);
        check("post_rst_valid", 32'(bus.inst_valid), 32'd0);
        ack_lat        = 0;
        bus.inst_ready = 1'b1;
        sb.push_back(RST_PC);
        drain("post_rst_drained");
        for (int i = 0; i < 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: imem_req  out  1  instruction-memory read request, held until acknowledged.
REQ-005 Port: imem_addr  out  32  word-aligned read address; stable while imem_req=1.
REQ-006 Port: imem_ack  in  1  one-cycle pulse; imem_data is valid in the same cycle.
REQ-007 Port: imem_data  in  32  returned instruction word.
REQ-008 Port: inst_valid  out  1  inst and inst_pc hold a valid instruction for the decoder.
REQ-009 Port: inst_ready  in  1  decoder accepts the instruction this cycle.
REQ-010 Port: inst  out  32  instruction word presented to the decoder.
REQ-011 Port: inst_pc  out  32  address of inst.
REQ-012 Port: redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
REQ-013 Port: redirect_pc  in  32  target address; bits [1:0] ignored and treated as 00.

Function
REQ-014 The block SHALL hold fetch_pc (32 bits) and a 2-entry FIFO of {inst, pc} pairs with occupancy count 0..2.
REQ-015 FSM states SHALL be IDLE (no request), WAIT (request outstanding, response kept) and DROP (request outstanding, response discarded).
REQ-016 imem_req SHALL be 1 exactly in WAIT and DROP; imem_addr SHALL equal the address latched at request start.
REQ-017 IDLE->WAIT SHALL occur when the next-cycle count is <2 and redirect=0, latching imem_addr=fetch_pc.
REQ-018 In WAIT, imem_ack=1 SHALL push {imem_data, imem_addr} into the FIFO and set fetch_pc=imem_addr+4.
REQ-019 On ack in WAIT: if the post-update count is <2, the FSM SHALL stay in WAIT with imem_addr=new fetch_pc (back-to-back); otherwise it SHALL go to IDLE.
REQ-020 A request SHALL never be outstanding while count=2; count SHALL never exceed 2.
REQ-021 inst_valid SHALL equal (count!=0); inst/inst_pc SHALL show the FIFO head and stay stable while inst_valid=1 and inst_ready=0.
REQ-022 inst_valid=1 and inst_ready=1 SHALL pop the head; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 Latency: ack in cycle N SHALL give inst_valid=1 with that word in cycle N+1 if the FIFO was empty.
REQ-024 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-025 redirect=1 SHALL set fetch_pc={redirect_pc[31:2],2'b00}, clear the FIFO (inst_valid=0 next cycle), and override any push or pop in that cycle.
REQ-026 redirect in WAIT without ack SHALL move to DROP; redirect in WAIT with ack SHALL discard that data and go to IDLE.
REQ-027 In DROP, imem_req SHALL stay 1 with the old address; ack SHALL discard data, leave fetch_pc unchanged and go to IDLE.
REQ-028 redirect in DROP SHALL update fetch_pc only; redirect in IDLE SHALL update fetch_pc and keep IDLE for that cycle.
REQ-029 imem_ack in IDLE SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, fetch_pc=RESET_PC, count=0, imem_req=0 and inst_valid=0; inst/inst_pc SHALL be 0.
REQ-031 Reset during WAIT or DROP SHALL abandon the request; a late ack after reset release SHALL be ignored under REQ-029.
REQ-032 The first imem_req=1 SHALL appear one cycle after the first rising edge with rst_n=1, with imem_addr=RESET_PC.

Verification
REQ-033 Reset release, ack every request with zero wait, inst_ready=1 -> inst_pc sequence 0,4,8,... with one instruction per cycle after the first.
REQ-034 inst_ready=0 with ack always ready -> exactly 2 instructions buffered (pc 0 and 4), then imem_req=0; inst stays at pc 0.
REQ-035 redirect=1 with redirect_pc=32'h0000_0103 while in WAIT, ack 2 cycles later -> acked data dropped, next imem_addr=32'h0000_0100, no stale inst_valid.
REQ-036 redirect in the same cycle as ack and pop with count=1 -> count=0 next cycle, state IDLE, fetch_pc=target.
REQ-037 RESET_PC=32'hFFFF_FFF8, stream 3 fetches -> inst_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst_n asserted mid-WAIT, then released, with a stray ack -> no push, first request at RESET_PC.
